// File: rtl/sr_flag_arbiter_if.sv
// sr_flag_arbiter_if: request/flag bus between requesters and the shared-SR arbiter.
// Optional SR_ERR_COUNT_EN adds the err_count status bus.
interface sr_flag_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0] req;
  logic [N-1:0] op;
  logic         q;
  logic         s;
  logic         r;
  logic [N-1:0] gnt;
  logic [N-1:0] done;
  logic         err;
`ifdef SR_ERR_COUNT_EN
  logic [7:0]   err_count;

  modport master (output req, op, q, input s, r, gnt, done, err, err_count);
  modport slave  (input req, op, q, output s, r, gnt, done, err, err_count);
`else
  modport master (output req, op, q, input s, r, gnt, done, err);
  modport slave  (input req, op, q, output s, r, gnt, done, err);
`endif
endinterface

// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: round-robin arbiter that lets N requesters set/reset one
// shared SR flip-flop and confirms the result by watching q.
// Optional feature: define SR_ERR_COUNT_EN to add a saturating err_count output.
//
// state | meaning
// IDLE  | no transaction; arbitrate when any req is high
// DRIVE | one-cycle s or r pulse for the latched winner
// CHECK | wait for q to match op_l, at most TIMEOUT cycles
// DONE  | pulse done[winner] (and err on timeout), advance ptr
module sr_flag_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 3
) (
  input logic               clk,
  input logic               rst,
  sr_flag_arbiter_if.slave  bus
);
  localparam int WW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  state_t          state, state_n;
  logic [WW-1:0]   winner, winner_n;
  logic [WW-1:0]   ptr, ptr_n;
  logic [WW-1:0]   pick;
  logic            op_l, op_l_n;
  logic            fail, fail_n;
  logic [3:0]      cnt, cnt_n;
  logic [N-1:0]    win_oh;

  // Round-robin search: first requester above ptr, wrapping modulo N.
  always_comb begin
    int  idx;
    logic found;
    found = 1'b0;
    pick  = ptr;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = WW'(idx);
      end
    end
  end

  // State and transaction context registers; reset leaves requester 0 first in line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      winner <= '0;
      ptr    <= WW'(N - 1);
      op_l   <= 1'b0;
      fail   <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      winner <= winner_n;
      ptr    <= ptr_n;
      op_l   <= op_l_n;
      fail   <= fail_n;
      cnt    <= cnt_n;
    end
  end

  // Next-state logic; req/op are only looked at in IDLE and q only in CHECK.
  always_comb begin
    state_n  = state;
    winner_n = winner;
    ptr_n    = ptr;
    op_l_n   = op_l;
    fail_n   = fail;
    cnt_n    = cnt;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          winner_n = pick;
          op_l_n   = bus.op[pick];
          state_n  = DRIVE;
        end
      end
      DRIVE: begin
        cnt_n   = '0;
        state_n = CHECK;
      end
      CHECK: begin
        if (bus.q == op_l) begin
          fail_n  = 1'b0;
          state_n = DONE;
        end else begin
          cnt_n = cnt + 4'd1;
          if (cnt == 4'(TIMEOUT - 1)) begin
            fail_n  = 1'b1;
            state_n = DONE;
          end
        end
      end
      DONE: begin
        ptr_n   = winner;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Moore output decode from registered state only, so s/r can never overlap.
  always_comb begin
    win_oh   = {{(N-1){1'b0}}, 1'b1} << winner;
    bus.s    = (state == DRIVE) &  op_l;
    bus.r    = (state == DRIVE) & ~op_l;
    bus.gnt  = (state != IDLE) ? win_oh : '0;
    bus.done = (state == DONE) ? win_oh : '0;
    bus.err  = (state == DONE) & fail;
  end

`ifdef SR_ERR_COUNT_EN
  logic [7:0] err_cnt_q;

  // Saturating count of timeout completions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_cnt_q <= '0;
    else if (state == DONE && fail && err_cnt_q != 8'hFF)
      err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign bus.err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Testbench for sr_flag_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level timeline model.
module tb_sr_flag_arbiter;
  localparam int N       = 4;
  localparam int TIMEOUT = 3;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   ptr_m;
  int   errs_m;

  sr_flag_arbiter_if #(.N(N)) bus ();

  sr_flag_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every sampled cycle: s and r never together, gnt at most one-hot.
  always @(negedge clk) begin
    tests++;
    assert (((bus.s & bus.r) == 1'b0) && $onehot0(bus.gnt))
    else begin
      fails++;
      $error("FAIL invariant: s=%0b r=%0b gnt=%0h required s&r=0 and onehot0 gnt", bus.s, bus.r, bus.gnt);
    end
  end

  function automatic int rr_pick(input int p, input logic [N-1:0] rq);
    for (int k = 1; k <= N; k++) begin
      if (rq[(p + k) % N]) return (p + k) % N;
    end
    return p;
  endfunction

  task automatic check_idle();
    check("idle_gnt",  32'(bus.gnt),  32'd0);
    check("idle_s",    32'(bus.s),    32'd0);
    check("idle_r",    32'(bus.r),    32'd0);
    check("idle_done", 32'(bus.done), 32'd0);
    check("idle_err",  32'(bus.err),  32'd0);
`ifdef SR_ERR_COUNT_EN
    check("err_count", 32'(bus.err_count), 32'(errs_m));
`endif
  endtask

  // One cycle with no request: nothing may be granted.
  task automatic idle_cycle();
    bus.req = '0;
    bus.op  = N'($urandom);
    bus.q   = 1'($urandom);
    @(negedge clk);
    check_idle();
    @(posedge clk); #1;
  endtask

  // One full transaction. m = index of the CHECK cycle where q first matches
  // (m >= TIMEOUT means never). mode: 0 hold req/op, 1 randomize, 2 drop req.
  task automatic run_txn(input logic [N-1:0] rq, input logic [N-1:0] o, input int m, input int mode);
    int   w;
    int   d;
    logic opw;
    logic err_e;
    bus.req = rq;
    bus.op  = o;
    bus.q   = 1'($urandom);
    @(negedge clk);
    check_idle();
    @(posedge clk); #1;
    w     = rr_pick(ptr_m, rq);
    opw   = o[w];
    d     = 2 + ((m < TIMEOUT) ? m + 1 : TIMEOUT);
    err_e = (m >= TIMEOUT);
    for (int t = 1; t <= d; t++) begin
      case (mode)
        0: ;
        1: begin bus.req = N'($urandom); bus.op = N'($urandom); end
        default: bus.req = '0;
      endcase
      if (t == 1) bus.q = 1'($urandom);
      else        bus.q = (t >= 2 + m) ? opw : ~opw;
      @(negedge clk);
      check("gnt",  32'(bus.gnt),  32'd1 << w);
      check("s",    32'(bus.s),    32'((t == 1) &&  opw));
      check("r",    32'(bus.r),    32'((t == 1) && !opw));
      check("done", 32'(bus.done), (t == d) ? (32'd1 << w) : 32'd0);
      check("err",  32'(bus.err),  32'((t == d) && err_e));
      @(posedge clk); #1;
    end
    ptr_m = w;
    if (err_e && errs_m < 255) errs_m++;
  endtask

  initial begin
    logic [N-1:0] rq;
    tests   = 0;
    fails   = 0;
    rst     = 1'b1;
    bus.req = '0;
    bus.op  = '0;
    bus.q   = 1'b0;
    ptr_m   = N - 1;
    errs_m  = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle();
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic set from reset, q follows immediately.
    run_txn(4'b0001, 4'b0001, 0, 0);
    // Held 1011 from ptr=0: order 1, 3, 0, 1.
    for (int i = 0; i < 4; i++) run_txn(4'b1011, N'($urandom), $urandom_range(0, TIMEOUT - 1), 0);
    // q stuck low on a set request: timeout with err.
    run_txn(4'b0100, 4'b0100, TIMEOUT, 0);
    // Flag already in requested state completes normally.
    run_txn(4'b0001, 4'b0000, 0, 1);
    // Requester 2 drops req during DRIVE; done still pulses, no regrant.
    run_txn(4'b0100, 4'b0000, 1, 2);
    idle_cycle();

    // Async reset during CHECK aborts with no pulses.
    bus.req = 4'b0010;
    bus.op  = 4'b0010;
    @(posedge clk); #1;
    bus.req = N'($urandom);
    @(posedge clk); #1;
    bus.q = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    errs_m = 0;
    ptr_m  = N - 1;
    check("rst_gnt",  32'(bus.gnt),  32'd0);
    check("rst_s",    32'(bus.s),    32'd0);
    check("rst_r",    32'(bus.r),    32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err",  32'(bus.err),  32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    run_txn(4'b1111, N'($urandom), 0, 1);

    // Randomized transactions.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      rq = N'($urandom_range(1, (1 << N) - 1));
      run_txn(rq, N'($urandom), $urandom_range(0, TIMEOUT), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
